outpkt_builder: RTL and testbench

- Transmit-side packet framer for the pkt_comm v2 output path.
- Takes completed comparator results and "processing done" notices from the sha256crypt arbiter.
- Serializes them into framed output packets (header, header checksum, payload, payload checksum) as 16-bit little-endian words.
- Writes them into the high-speed output FIFO (dout/wr_en/full), the same stream that leaves the FPGA via output_fifo.

---
 rtl/pkt_comm_out_pkg.sv | 11 +
 rtl/outpkt_builder_if.sv | 27 ++
 rtl/outpkt_checksum16.sv | 25 ++
 rtl/outpkt_builder.sv | 84 ++++++++
 tb/tb_outpkt_builder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_comm_out_pkg.sv
// pkt_comm_out_pkg: packet types, section sizes, FSM states and payload length for the output framer
package pkt_comm_out_pkg;
  localparam logic [7:0] PKT_TYPE_CMP_RESULT = 8'hD4;
  localparam logic [7:0] PKT_TYPE_PROCESSING_DONE = 8'hD2;
  localparam int HDR_WORDS = 6;
  localparam int CS_WORDS = 2;
  typedef enum logic [2:0] {IDLE, HDR, HCS, DATA, DCS} state_t;
  function automatic logic [23:0] cmp_len(input int hash_words);
    return 24'(12 + 4 * hash_words);
  endfunction
endpackage

// File: rtl/outpkt_builder_if.sv
// outpkt_builder_if: request handshakes, output FIFO write port and status of the packet framer
interface outpkt_builder_if #(parameter int HASH_WORDS = 8);
  logic res_valid;
  logic res_ready;
  logic [15:0] res_word_id;
  logic [15:0] res_pkt_id;
  logic [31:0] res_gen_id;
  logic [15:0] res_hash_num;
  logic [32*HASH_WORDS-1:0] res_hash;
  logic done_valid;
  logic done_ready;
  logic [31:0] done_num;
  logic [15:0] dout;
  logic wr_en;
  logic full;
  logic idle;
  modport master (
    output res_valid, res_word_id, res_pkt_id, res_gen_id, res_hash_num, res_hash,
    output done_valid, done_num, full,
    input res_ready, done_ready, dout, wr_en, idle
  );
  modport slave (
    input res_valid, res_word_id, res_pkt_id, res_gen_id, res_hash_num, res_hash,
    input done_valid, done_num, full,
    output res_ready, done_ready, dout, wr_en, idle
  );
endinterface

// File: rtl/outpkt_checksum16.sv
// outpkt_checksum16: pairs 16-bit words into little-endian dwords and keeps their inverted mod-2^32 sum
module outpkt_checksum16 #(
  parameter bit DISABLE_CHECKSUM = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic        odd_i,
  input  logic [15:0] din_i,
  output logic [31:0] cs_o
);
  logic [15:0] even_q;
  logic [31:0] acc_q;
  always_ff @(posedge CLK) begin
    if (!RST_N || clr_i) begin
      even_q <= '0;
      acc_q <= '0;
    end else if (add_i) begin
      even_q <= odd_i ? even_q : din_i;
      acc_q <= odd_i ? acc_q + {din_i, even_q} : acc_q;
    end
  end
  assign cs_o = DISABLE_CHECKSUM ? 32'h0 : ~acc_q;
endmodule

// File: rtl/outpkt_builder.sv
// outpkt_builder: frames comparator results and processing-done notices into 16-bit output FIFO packets
module outpkt_builder
  import pkt_comm_out_pkg::*;
#(
  parameter int HASH_WORDS = 8,
  parameter bit DISABLE_CHECKSUM = 0,
  parameter logic [7:0] PKT_VERSION = 8'd2
) (
  input logic CLK,
  input logic RST_N,
  outpkt_builder_if.slave bus
);
  localparam logic [15:0] HDR_LAST = 16'(HDR_WORDS - 1);
  localparam logic [15:0] CS_LAST = 16'(CS_WORDS - 1);
  localparam logic [15:0] RES_LAST = 16'(5 + 2 * HASH_WORDS);
  localparam logic [23:0] RES_LEN = cmp_len(HASH_WORDS);
  state_t state_q, nxt;
  logic [15:0] cnt_q, pkt_id_q, word_id_q, src_pkt_id_q, hash_num_q;
  logic [31:0] gen_id_q, done_num_q, cs;
  logic [32*HASH_WORDS-1:0] hash_q, hash_sh;
  logic is_res_q, accept, wr, last;
  logic [23:0] len;
  logic [15:0] hdr_w, res_w, pay_w, cs_w;
  assign accept = state_q == IDLE && (bus.res_valid || bus.done_valid);
  assign bus.res_ready = state_q == IDLE && bus.res_valid;
  assign bus.done_ready = state_q == IDLE && !bus.res_valid && bus.done_valid;
  assign bus.idle = state_q == IDLE && !accept;
  assign wr = state_q != IDLE && !bus.full;
  assign bus.wr_en = wr;
  always_comb begin
    len = is_res_q ? RES_LEN : 24'd4;
    last = cnt_q == (state_q == HDR ? HDR_LAST : state_q == DATA ? (is_res_q ? RES_LAST : 16'd1) : CS_LAST);
    nxt = state_q == HDR ? HCS : state_q == HCS ? DATA : state_q == DATA ? DCS : IDLE;
    hash_sh = hash_q >> {cnt_q - 16'd6, 4'd0};
    hdr_w = cnt_q == 16'd0 ? {is_res_q ? PKT_TYPE_CMP_RESULT : PKT_TYPE_PROCESSING_DONE, PKT_VERSION} :
            cnt_q == 16'd2 ? len[15:0] :
            cnt_q == 16'd3 ? {8'h0, len[23:16]} :
            cnt_q == 16'd4 ? pkt_id_q : 16'h0;
    res_w = cnt_q == 16'd0 ? word_id_q :
            cnt_q == 16'd1 ? src_pkt_id_q :
            cnt_q == 16'd2 ? gen_id_q[15:0] :
            cnt_q == 16'd3 ? gen_id_q[31:16] :
            cnt_q == 16'd4 ? hash_num_q :
            cnt_q == 16'd5 ? 16'h0 : hash_sh[15:0];
    pay_w = is_res_q ? res_w : cnt_q[0] ? done_num_q[31:16] : done_num_q[15:0];
    cs_w = cnt_q[0] ? cs[31:16] : cs[15:0];
  end
  assign bus.dout = state_q == HDR ? hdr_w : state_q == DATA ? pay_w : state_q == IDLE ? 16'h0 : cs_w;
  outpkt_checksum16 #(.DISABLE_CHECKSUM(DISABLE_CHECKSUM)) u_cs (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr_i (accept || (state_q == HCS && wr && last)),
    .add_i (wr && (state_q == HDR || state_q == DATA)),
    .odd_i (cnt_q[0]),
    .din_i (bus.dout),
    .cs_o  (cs)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pkt_id_q <= '0;
      is_res_q <= 1'b0;
    end else if (state_q == IDLE) begin
      state_q <= accept ? HDR : IDLE;
      cnt_q <= '0;
      is_res_q <= accept ? bus.res_valid : is_res_q;
    end else if (wr) begin
      cnt_q <= last ? '0 : cnt_q + 16'd1;
      state_q <= last ? nxt : state_q;
      pkt_id_q <= (last && state_q == DCS) ? pkt_id_q + 16'd1 : pkt_id_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (bus.res_ready) begin
      word_id_q <= bus.res_word_id;
      src_pkt_id_q <= bus.res_pkt_id;
      gen_id_q <= bus.res_gen_id;
      hash_num_q <= bus.res_hash_num;
      hash_q <= bus.res_hash;
    end
    if (bus.done_ready) done_num_q <= bus.done_num;
  end
endmodule

// File: tb/tb_outpkt_builder.sv
// tb_outpkt_builder: scoreboard bench for the output packet framer, normal and checksum-disabled builds
module tb_outpkt_builder;
  localparam int HW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] pay[$];
  logic [7:0] sec[$];
  logic [15:0] exp0[$], exp1[$], got0[$], got1[$];
  always #5 clk = ~clk;
  outpkt_builder_if #(.HASH_WORDS(HW)) b0 ();
  outpkt_builder_if #(.HASH_WORDS(HW)) b1 ();
  outpkt_builder #(.HASH_WORDS(HW)) dut0 (.CLK(clk), .RST_N(rst_n), .bus(b0));
  outpkt_builder #(.HASH_WORDS(HW), .DISABLE_CHECKSUM(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    logic [31:0] e;
    if (b0.wr_en === 1'b1) begin
      got0.push_back(b0.dout);
      e = exp0.size() != 0 ? {16'h0, exp0.pop_front()} : 32'hDEAD_0000;
      chk("dout0", {16'h0, b0.dout}, e);
    end
    if (b1.wr_en === 1'b1) begin
      got1.push_back(b1.dout);
      e = exp1.size() != 0 ? {16'h0, exp1.pop_front()} : 32'hDEAD_0000;
      chk("dout1", {16'h0, b1.dout}, e);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input bit s, input logic [15:0] w);
    if (s) exp1.push_back(w);
    else exp0.push_back(w);
  endtask
  task automatic push_sec(input bit s, input bit nocs);
    logic [31:0] sum;
    sum = 32'h0;
    for (int i = 0; i < sec.size(); i += 2) push_word(s, {sec[i+1], sec[i]});
    for (int i = 0; i < sec.size(); i += 4) sum += {sec[i+3], sec[i+2], sec[i+1], sec[i]};
    sum = nocs ? 32'h0 : ~sum;
    push_word(s, sum[15:0]);
    push_word(s, sum[31:16]);
  endtask
  task automatic push_pkt(input bit s, input logic [7:0] typ, input logic [15:0] pid, input bit nocs);
    logic [23:0] len;
    len = 24'(pay.size());
    sec.delete();
    sec.push_back(8'd2); sec.push_back(typ); sec.push_back(8'h0); sec.push_back(8'h0);
    sec.push_back(len[7:0]); sec.push_back(len[15:8]); sec.push_back(len[23:16]); sec.push_back(8'h0);
    sec.push_back(pid[7:0]); sec.push_back(pid[15:8]); sec.push_back(8'h0); sec.push_back(8'h0);
    push_sec(s, nocs);
    sec = pay;
    push_sec(s, nocs);
  endtask
  task automatic arm_done(input bit s, input logic [31:0] n, input logic [15:0] pid);
    pay.delete();
    for (int k = 0; k < 4; k++) pay.push_back(n[8*k +: 8]);
    push_pkt(s, 8'hD2, pid, s);
    if (s) begin
      b1.done_num = n;
      b1.done_valid = 1'b1;
    end else begin
      b0.done_num = n;
      b0.done_valid = 1'b1;
    end
  endtask
  task automatic arm_res(input logic [15:0] wid, input logic [15:0] spid, input logic [31:0] gid,
                         input logic [15:0] hn, input logic [32*HW-1:0] h, input logic [15:0] pid);
    pay.delete();
    pay.push_back(wid[7:0]); pay.push_back(wid[15:8]);
    pay.push_back(spid[7:0]); pay.push_back(spid[15:8]);
    for (int k = 0; k < 4; k++) pay.push_back(gid[8*k +: 8]);
    pay.push_back(hn[7:0]); pay.push_back(hn[15:8]);
    pay.push_back(8'h0); pay.push_back(8'h0);
    for (int k = 0; k < 4 * HW; k++) pay.push_back(h[8*k +: 8]);
    push_pkt(1'b0, 8'hD4, pid, 1'b0);
    b0.res_word_id = wid;
    b0.res_pkt_id = spid;
    b0.res_gen_id = gid;
    b0.res_hash_num = hn;
    b0.res_hash = h;
    b0.res_valid = 1'b1;
  endtask
  task automatic rand_hash(output logic [32*HW-1:0] h);
    for (int k = 0; k < HW; k++) h[32*k +: 32] = $urandom;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (!(b0.idle === 1'b1 && b1.idle === 1'b1) && n < 1000) begin
      tick();
      n++;
    end
  endtask
  initial begin
    int n;
    logic [15:0] held;
    logic [31:0] pcs;
    logic [32*HW-1:0] h;
    b0.res_valid = 0; b0.res_word_id = 0; b0.res_pkt_id = 0; b0.res_gen_id = 0;
    b0.res_hash_num = 0; b0.res_hash = '0; b0.done_valid = 0; b0.done_num = 0; b0.full = 0;
    b1.res_valid = 0; b1.res_word_id = 0; b1.res_pkt_id = 0; b1.res_gen_id = 0;
    b1.res_hash_num = 0; b1.res_hash = '0; b1.done_valid = 0; b1.done_num = 0; b1.full = 0;
    tick();
    tick();
    chk("rst_wr_en", b0.wr_en, 0);
    chk("rst_dout", b0.dout, 0);
    chk("rst_idle", b0.idle, 1);
    chk("rst_res_ready", b0.res_ready, 0);
    chk("rst_done_ready", b0.done_ready, 0);
    chk("rst_idle1", b1.idle, 1);
    rst_n = 1'b1;
    tick();
    arm_done(1'b0, 32'd8, 16'd0);
    arm_done(1'b1, 32'd8, 16'd0);
    #1;
    chk("done_ready", b0.done_ready, 1);
    chk("idle_on_accept", b0.idle, 0);
    tick();
    b0.done_valid = 0;
    b1.done_valid = 0;
    chk("first_wr", b0.wr_en, 1);
    chk("first_word", b0.dout, 16'hD202);
    wait_idle(n);
    chk("done_cycles", n, 12);
    chk("done_count", got0.size(), 12);
    chk("done_w2", got0[2], 16'h0004);
    chk("done_hcs0", got0[6], 16'h2DF9);
    chk("done_hcs1", got0[7], 16'hFFFF);
    chk("done_pay0", got0[8], 16'h0008);
    chk("done_dcs0", got0[10], 16'hFFF7);
    chk("done_dcs1", got0[11], 16'hFFFF);
    chk("nocs_count", got1.size(), 12);
    chk("nocs_hcs0", got1[6], 16'h0000);
    chk("nocs_hcs1", got1[7], 16'h0000);
    chk("nocs_pay0", got1[8], 16'h0008);
    chk("nocs_dcs0", got1[10], 16'h0000);
    chk("nocs_dcs1", got1[11], 16'h0000);
    got0.delete();
    got1.delete();
    h = '0;
    h[31:0] = 32'h978171EB;
    arm_res(16'd1, 16'd2, 32'd3, 16'd0, h, 16'd1);
    #1;
    chk("res_ready", b0.res_ready, 1);
    tick();
    b0.res_valid = 0;
    wait_idle(n);
    chk("res_cycles", n, 32);
    chk("res_count", got0.size(), 32);
    chk("res_h0", got0[0], 16'hD402);
    chk("res_h1", got0[1], 16'h0000);
    chk("res_h2", got0[2], 16'h002C);
    chk("res_h3", got0[3], 16'h0000);
    chk("res_h4", got0[4], 16'h0001);
    chk("res_h5", got0[5], 16'h0000);
    pcs = ~(32'h00020001 + 32'h00000003 + 32'h978171EB);
    chk("res_dcs0", got0[30], {16'h0, pcs[15:0]});
    chk("res_dcs1", got0[31], {16'h0, pcs[31:16]});
    got0.delete();
    rand_hash(h);
    arm_res(16'($urandom), 16'($urandom), $urandom, 16'($urandom), h, 16'd2);
    tick();
    b0.res_valid = 0;
    repeat (7) tick();
    b0.full = 1'b1;
    #1;
    held = b0.dout;
    chk("stall_word", held, exp0[0]);
    chk("stall_wr0", b0.wr_en, 0);
    repeat (4) begin
      tick();
      chk("stall_hold", b0.dout, held);
      chk("stall_wr", b0.wr_en, 0);
    end
    tick();
    b0.full = 1'b0;
    wait_idle(n);
    chk("stall_cycles", n, 25);
    chk("stall_count", got0.size(), 32);
    got0.delete();
    rand_hash(h);
    arm_res(16'($urandom), 16'($urandom), $urandom, 16'($urandom), h, 16'd3);
    arm_done(1'b0, 32'h1234_5678, 16'd4);
    #1;
    chk("prio_res_ready", b0.res_ready, 1);
    chk("prio_done_ready", b0.done_ready, 0);
    tick();
    b0.res_valid = 0;
    chk("busy_done_ready", b0.done_ready, 0);
    n = 0;
    while (b0.done_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("prio_gap", n, 32);
    tick();
    b0.done_valid = 0;
    wait_idle(n);
    chk("prio_done_cycles", n, 12);
    chk("prio_count", got0.size(), 44);
    chk("prio_res_pid", got0[4], 16'd3);
    chk("prio_done_pid", got0[36], 16'd4);
    got0.delete();
    rand_hash(h);
    arm_res(16'($urandom), 16'($urandom), $urandom, 16'($urandom), h, 16'd5);
    tick();
    b0.res_valid = 0;
    repeat (11) tick();
    chk("pre_rst_word", b0.dout, exp0[0]);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr", b0.wr_en, 0);
    chk("mid_rst_idle", b0.idle, 1);
    chk("mid_rst_written", got0.size(), 12);
    chk("mid_rst_left", exp0.size(), 20);
    exp0.delete();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_written", got0.size(), 12);
    got0.delete();
    arm_done(1'b0, 32'h0000_0001, 16'd0);
    tick();
    b0.done_valid = 0;
    wait_idle(n);
    chk("post_rst_cycles", n, 12);
    chk("post_rst_pid", got0[4], 16'd0);
    chk("sb0_empty", exp0.size(), 0);
    chk("sb1_empty", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
